// File: rtl/shk_uart_wr_arbiter_pkg.sv
// shk_uart_pkg: shared FSM states, width helper and phase encoding for the shake-write UART arbiter
package shk_uart_pkg;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, ERR} state_t;

    // Phase encoding on the UART port: bit0 = valid, bit1 = msync
    localparam logic [1:0] PH_NONE = 2'b00;
    localparam logic [1:0] PH_ADDR = 2'b01;
    localparam logic [1:0] PH_DATA = 2'b11;

    function automatic int shk_log2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic logic [1:0] shk_phase(input state_t s);
        return s == ADDR ? PH_ADDR : s == DATA ? PH_DATA : PH_NONE;
    endfunction

endpackage

// File: rtl/shk_uart_wr_arbiter_if.sv
// shk_uart_wr_arbiter_if: shake-write UART port (addr byte with valid, data byte with msync, ready per byte)
interface shk_uart_wr_arbiter_if #(
    parameter int WD_SHK_ADDR = 8,
    parameter int WD_SHK_DATA = 8
);
    logic                   wr_valid;
    logic                   wr_msync;
    logic                   wr_ready;
    logic [WD_SHK_ADDR-1:0] wr_maddr;
    logic [WD_SHK_DATA-1:0] wr_mdata;

    modport master (output wr_valid, wr_msync, wr_maddr, wr_mdata, input wr_ready);
    modport slave  (input wr_valid, wr_msync, wr_maddr, wr_mdata, output wr_ready);
endinterface

// File: rtl/shk_uart_wr_arbiter_rr.sv
// shk_rr_arbiter: combinational round-robin picker, first set request searching upward from ptr+1 with wrap
module shk_rr_arbiter import shk_uart_pkg::*; #(
    parameter  int NB_REQ = 4,
    localparam int WI     = shk_log2(NB_REQ)
) (
    input  logic [NB_REQ-1:0] req,
    input  logic [WI-1:0]     ptr,
    output logic [NB_REQ-1:0] onehot,
    output logic [WI-1:0]     idx,
    output logic              any
);
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 1; i <= NB_REQ; i++) begin
            if (!any && req[(int'(ptr) + i) % NB_REQ]) begin
                any                                = 1'b1;
                onehot[(int'(ptr) + i) % NB_REQ]   = 1'b1;
                idx                                = WI'((int'(ptr) + i) % NB_REQ);
            end
        end
    end
endmodule

// File: rtl/shk_uart_wr_arbiter.sv
// shk_uart_wr_arbiter: round-robin sharing of one shake-write UART TX among NB_REQ (addr, data) requesters.
// Define SHK_UART_ARB_TIMEOUT_EN to abort a phase after NB_TIMEOUT cycles without ready.
module shk_uart_wr_arbiter import shk_uart_pkg::*; #(
    parameter  int NB_REQ      = 4,
    parameter  int WD_SHK_DATA = 8,
    parameter  int WD_SHK_ADDR = 8,
    parameter  int NB_TIMEOUT  = 24000,
    localparam int WI          = shk_log2(NB_REQ)
) (
    input  logic                          i_sys_clk,
    input  logic                          i_sys_reset,
    input  logic [NB_REQ-1:0]             s_req_valid,
    input  logic [NB_REQ*WD_SHK_ADDR-1:0] s_req_addr,
    input  logic [NB_REQ*WD_SHK_DATA-1:0] s_req_data,
    output logic [NB_REQ-1:0]             s_req_grant,
    output logic [NB_REQ-1:0]             s_req_done,
    output logic [NB_REQ-1:0]             s_req_err,
    shk_uart_wr_arbiter_if.master         m_shk,
    output logic                          o_busy,
    output logic [WI-1:0]                 o_grant_idx
);
    state_t            state_q, state_d;
    logic [WI-1:0]     ptr_q, pick_idx;
    logic [NB_REQ-1:0] pick_oh, win_oh;
    logic              pick_any, first_q, rdy, tmo;

    shk_rr_arbiter #(.NB_REQ(NB_REQ)) u_rr (
        .req    (s_req_valid),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // first_q marks a phase entry cycle, where a ready pulse belongs to the previous byte
    assign rdy    = m_shk.wr_ready && !first_q;
    assign win_oh = NB_REQ'(1) << o_grant_idx;
    assign o_busy = state_q != IDLE;

`ifdef SHK_UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(NB_TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    always_ff @(posedge i_sys_clk)
        cnt_q <= (i_sys_reset || state_d != state_q) ? '0 : cnt_q + 1'b1;
    assign tmo = cnt_q == CW'(NB_TIMEOUT - 1);
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = pick_any ? ADDR : IDLE;
            ADDR:    state_d = rdy ? DATA : tmo ? ERR : ADDR;
            DATA:    state_d = rdy ? DONE : tmo ? ERR : DATA;
            default: state_d = IDLE;
        endcase
        s_req_grant = (state_q == IDLE && !i_sys_reset) ? pick_oh : '0;
        s_req_done  = state_q == DONE ? win_oh : '0;
        s_req_err   = state_q == ERR ? win_oh : '0;
        {m_shk.wr_msync, m_shk.wr_valid} = shk_phase(state_q);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            state_q        <= IDLE;
            ptr_q          <= WI'(NB_REQ - 1);
            o_grant_idx    <= '0;
            first_q        <= 1'b0;
            m_shk.wr_maddr <= '0;
            m_shk.wr_mdata <= '0;
        end else begin
            state_q <= state_d;
            first_q <= state_d != state_q;
            if (state_q == IDLE && pick_any) begin
                o_grant_idx    <= pick_idx;
                m_shk.wr_maddr <= s_req_addr[pick_idx*WD_SHK_ADDR +: WD_SHK_ADDR];
                m_shk.wr_mdata <= s_req_data[pick_idx*WD_SHK_DATA +: WD_SHK_DATA];
            end
            if (state_q == DONE || state_q == ERR)
                ptr_q <= o_grant_idx;
        end
    end
endmodule

// File: tb/tb_shk_uart_wr_arbiter.sv
// tb_shk_uart_wr_arbiter: directed stimulus with a timestamp-based transaction model checked every cycle
module tb_shk_uart_wr_arbiter;
    localparam int N = 4;
    localparam int T = 100;

    logic         clk = 1'b0, rst = 1'b1, ready = 1'b0, hold = 1'b0;
    logic [N-1:0] req = '0, g_seen = '0;
    logic [31:0]  abus = 32'hA3A2_A15A, dbus = 32'hD3D2_D1C3;
    logic [N-1:0] grant, done, err;
    logic         busy;
    logic [1:0]   gidx;
    int           total = 0, bad = 0, cyc = 0, err_seen = 0;

    shk_uart_wr_arbiter_if #(.WD_SHK_ADDR(8), .WD_SHK_DATA(8)) shk ();
    assign shk.wr_ready = ready;

    shk_uart_wr_arbiter #(.NB_REQ(N), .WD_SHK_DATA(8), .WD_SHK_ADDR(8), .NB_TIMEOUT(T)) dut (
        .i_sys_clk   (clk),
        .i_sys_reset (rst),
        .s_req_valid (req),
        .s_req_addr  (abus),
        .s_req_data  (dbus),
        .s_req_grant (grant),
        .s_req_done  (done),
        .s_req_err   (err),
        .m_shk       (shk),
        .o_busy      (busy),
        .o_grant_idx (gidx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Transaction model: grant at cycle tg, accepted readies at tr1/tr2, done one cycle after tr2
    int         act = 0, who = 0, ptr = N - 1, tg = 0, tr1 = -1, tr2 = -1;
    logic [7:0] ma = '0, md = '0;

    always @(negedge clk) begin
        int           w;
        logic [N-1:0] eg;
        logic         ev, em, eerr;
        cyc++;
        g_seen = grant;
        w      = rr_pick(req, ptr);
        eg     = (act == 0 && !rst && w >= 0) ? N'(1) << w : '0;
        eerr   = 1'b0;
`ifdef SHK_UART_ARB_TIMEOUT_EN
        eerr = act != 0 && tr2 < 0 && cyc == (tr1 < 0 ? tg + 1 : tr1 + 1) + T;
`endif
        ev = act != 0 && !eerr && (tr2 < 0 || cyc <= tr2);
        em = ev && tr1 >= 0 && cyc > tr1;
        chk("grant", grant, eg);
        chk("done", done, (act != 0 && tr2 >= 0 && cyc == tr2 + 1) ? N'(1) << who : '0);
        chk("err", err, eerr ? N'(1) << who : '0);
        chk("valid", shk.wr_valid, ev);
        chk("msync", shk.wr_msync, em);
        chk("busy", busy, act != 0);
        chk("grant_idx", gidx, who);
        chk("maddr", shk.wr_maddr, ma);
        chk("mdata", shk.wr_mdata, md);
        if (|err) err_seen++;
        if (rst) begin
            act = 0; who = 0; ptr = N - 1; ma = '0; md = '0; tr1 = -1; tr2 = -1;
        end else if (act == 0) begin
            if (w >= 0) begin
                act = 1; who = w; tg = cyc; tr1 = -1; tr2 = -1;
                ma = abus[w*8 +: 8];
                md = dbus[w*8 +: 8];
            end
        end else if (eerr || (tr2 >= 0 && cyc == tr2 + 1)) begin
            act = 0; ptr = who;
        end else if (tr1 < 0 && ready && cyc >= tg + 2) tr1 = cyc;
        else if (tr1 >= 0 && ready && cyc >= tr1 + 2) tr2 = cyc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold) req = req & ~g_seen;
        ready = 1'b0;
    endtask

    task automatic pulse();
        ready = 1'b1;
        tick();
    endtask

    task automatic serve();
        tick(); tick(); pulse(); tick(); pulse(); tick();
    endtask

    task automatic reset_dut();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish within budget");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        reset_dut();
        @(negedge clk);
        chk("rst_valid", shk.wr_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_idx", gidx, 2'd0);
        tick(); pulse();
        @(negedge clk); chk("idle_ready_busy", busy, 1'b0);
        // single request, byte values on the port
        tick(); req = 4'b0001;
        @(negedge clk); chk("t1_grant", grant, 4'b0001);
        tick();
        @(negedge clk); chk("t1_valid", shk.wr_valid, 1'b1); chk("t1_maddr", shk.wr_maddr, 8'h5A); chk("t1_msync0", shk.wr_msync, 1'b0);
        tick(); pulse();
        @(negedge clk); chk("t1_msync1", shk.wr_msync, 1'b1); chk("t1_mdata", shk.wr_mdata, 8'hC3);
        tick(); pulse();
        @(negedge clk); chk("t1_done", done, 4'b0001); chk("t1_valid_low", shk.wr_valid, 1'b0);
        // ready on phase entry cycles is ignored
        tick(); req = 4'b1000;
        @(negedge clk); chk("t5_grant", grant, 4'b1000);
        tick(); pulse();
        @(negedge clk); chk("t5_entry_ready", shk.wr_msync, 1'b0); chk("t5_busy", busy, 1'b1);
        tick(); pulse(); pulse();
        @(negedge clk); chk("t5_data_entry_ready", done, 4'b0000); chk("t5_still_data", shk.wr_msync, 1'b1);
        tick(); pulse();
        @(negedge clk); chk("t5_done", done, 4'b1000);
        // two simultaneous requesters after reset
        tick(); reset_dut(); req = 4'b0110;
        @(negedge clk); chk("t2_first", grant, 4'b0010);
        serve();
        @(negedge clk); chk("t2_second", grant, 4'b0100);
        serve();
        // all four held high continuously
        reset_dut(); hold = 1'b1; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk("t3_order", grant, 4'b0001 << (k % 4));
            serve();
        end
        hold = 1'b0; req = '0;
        // reset while in DATA
        reset_dut(); req = 4'b0001;
        tick(); tick(); pulse();
        @(negedge clk); chk("t4_in_data", shk.wr_msync, 1'b1);
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        chk("t4_valid", shk.wr_valid, 1'b0); chk("t4_msync", shk.wr_msync, 1'b0);
        chk("t4_busy", busy, 1'b0); chk("t4_done", done, 4'b0000);
        tick(); req = 4'b0011;
        @(negedge clk); chk("t4_req0_first", grant, 4'b0001);
        serve(); serve();
        // ready never returned
        req = 4'b0001;
        tick();
        repeat (T + 20) tick();
        @(negedge clk);
`ifdef SHK_UART_ARB_TIMEOUT_EN
        chk("t6_err_count", err_seen, 1);
        chk("t6_idle_after_err", busy, 1'b0);
`else
        chk("t6_err_count", err_seen, 0);
        chk("t6_still_addr", shk.wr_valid, 1'b1);
        chk("t6_busy", busy, 1'b1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
